// File: rtl/pdm_pkg.sv
// Shared types and defaults for the PDM transmit path.
package pdm_pkg;

  typedef enum logic {
    OFF = 1'b0,
    RUN = 1'b1
  } state_t;

  localparam int DEF_CLK_DIV = 50;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_OSR     = 64;

  // Two's complement -> offset binary for a w-bit sample held in the low bits.
  function automatic logic [31:0] to_offset(input logic [31:0] s, input int unsigned w);
    return s ^ (32'd1 << (w - 1));
  endfunction

endpackage

// File: rtl/pdm_tx_if.sv
// PCM sample stream (valid/ready) feeding the PDM transmitter.
interface pdm_tx_if
  import pdm_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/pdm_clk_gen.sv
// PDM bit clock divider; bit_tick marks the clk cycle ending with an mclk rise.
module pdm_clk_gen
  import pdm_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic mclk,
  output logic bit_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] div_cnt_reg;
  logic          mclk_reg;
  logic          div_wrap;

  assign div_wrap = (div_cnt_reg == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_reg <= '0;
      mclk_reg    <= 1'b0;
    end else if (!run || clear) begin
      div_cnt_reg <= '0;
      mclk_reg    <= 1'b0;
    end else if (div_wrap) begin
      div_cnt_reg <= '0;
      mclk_reg    <= ~mclk_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  assign mclk     = mclk_reg;
  assign bit_tick = run & ~clear & div_wrap & ~mclk_reg;

endmodule

// File: rtl/pdm_tx.sv
// PCM-to-PDM transmitter: one-deep sample buffer, frame counter and
// first-order sigma-delta modulator driving the amplifier pins.
module pdm_tx
  import pdm_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int OSR     = DEF_OSR
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  pdm_tx_if.slave        s,
  output logic           mclk,
  output logic           ampPWM,
  output logic           ampSD,
  output logic           sample_tick,
  output logic           underrun
);

  localparam int OW = (OSR > 1) ? $clog2(OSR) : 1;

  state_t            state_reg, state_next;
  logic [OW-1:0]     osr_cnt_reg;
  logic [DATA_W-1:0] acc_reg;
  logic [DATA_W-1:0] cur_reg;
  logic [DATA_W-1:0] pend_reg;
  logic              pend_full_reg;
  logic              pwm_reg;

  logic              running;
  logic              leaving;
  logic              bit_tick;
  logic              frame_edge;
  logic              frame_load;
  logic              take;
  logic [DATA_W-1:0] sample_eff;
  logic [DATA_W-1:0] u;
  logic [DATA_W:0]   sum;

  assign running = (state_reg == RUN);
  assign leaving = running & ~enable;

  pdm_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .reset    (reset),
    .run      (running),
    .clear    (leaving),
    .mclk     (mclk),
    .bit_tick (bit_tick)
  );

  assign frame_edge = bit_tick & (osr_cnt_reg == OW'(OSR - 1));
  assign frame_load = frame_edge & pend_full_reg;
  assign s.s_ready  = running & (~pend_full_reg | frame_load);
  assign take       = s.s_valid & s.s_ready;

  // A sample loaded at a frame edge already drives that edge's modulator bit.
  assign sample_eff = frame_load ? pend_reg : cur_reg;
  assign u          = DATA_W'(to_offset(32'(sample_eff), DATA_W));
  assign sum        = {1'b0, acc_reg} + {1'b0, u};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= OFF;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      OFF:     if (enable)  state_next = RUN;
      RUN:     if (!enable) state_next = OFF;
      default: state_next = OFF;
    endcase
  end

  // The accumulator carry is exactly the emitted bit, so only the low
  // DATA_W bits need to be kept between ticks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      osr_cnt_reg   <= '0;
      acc_reg       <= '0;
      cur_reg       <= '0;
      pend_reg      <= '0;
      pend_full_reg <= 1'b0;
      pwm_reg       <= 1'b0;
    end else if (!running || leaving) begin
      osr_cnt_reg   <= OW'(OSR - 1);
      acc_reg       <= '0;
      pend_full_reg <= 1'b0;
      pwm_reg       <= 1'b0;
    end else begin
      if (bit_tick) begin
        pwm_reg     <= sum[DATA_W];
        acc_reg     <= sum[DATA_W-1:0];
        osr_cnt_reg <= frame_edge ? '0 : osr_cnt_reg + 1'b1;
      end
      if (frame_load) begin
        cur_reg <= pend_reg;
      end
      if (take) begin
        pend_reg      <= s.s_data;
        pend_full_reg <= 1'b1;
      end else if (frame_load) begin
        pend_full_reg <= 1'b0;
      end
    end
  end

  assign ampPWM      = pwm_reg;
  assign ampSD       = running;
  assign sample_tick = frame_edge;
  assign underrun    = frame_edge & ~pend_full_reg;

endmodule

// File: tb/tb_pdm_tx.sv
// Directed bench for pdm_tx with CLK_DIV=2, OSR=8, DATA_W=16.
module tb_pdm_tx;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic mclk, ampPWM, ampSD, sample_tick, underrun;

  pdm_tx_if #(.DATA_W(16)) sif ();

  pdm_tx #(
    .CLK_DIV (2),
    .DATA_W  (16),
    .OSR     (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .s           (sif),
    .mclk        (mclk),
    .ampPWM      (ampPWM),
    .ampSD       (ampSD),
    .sample_tick (sample_tick),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] feed_q[$];
  bit          endless = 1'b0;
  logic [15:0] endless_val = '0;
  bit          win = 1'b0;
  int          win_acc = 0, win_st = 0, win_ur = 0, win_rdy_mis = 0;
  logic        prev_mclk = 1'b0;
  bit          rose = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // One clk cycle: drive the source at the falling edge, then observe.
  task automatic cycle();
    @(negedge clk);
    if (endless) begin
      sif.s_valid = 1'b1;
      sif.s_data  = endless_val;
    end else if (feed_q.size() > 0) begin
      sif.s_valid = 1'b1;
      sif.s_data  = feed_q[0];
    end else begin
      sif.s_valid = 1'b0;
    end
    rose      = mclk && !prev_mclk;
    prev_mclk = mclk;
    if (sif.s_valid && sif.s_ready) begin
      if (!endless) void'(feed_q.pop_front());
      if (win) win_acc++;
    end
    if (win) begin
      if (sample_tick) win_st++;
      if (underrun) win_ur++;
      if (sif.s_ready !== sample_tick) win_rdy_mis++;
    end
  endtask

  // Run until the next mclk rise; return the new PDM bit and flags seen on the way.
  task automatic next_bit(output logic b, output logic st, output logic ur, output int n);
    st = 1'b0;
    ur = 1'b0;
    b  = 1'b0;
    n  = 0;
    while (n < 64) begin
      cycle();
      n++;
      if (sample_tick) st = 1'b1;
      if (underrun) ur = 1'b1;
      if (rose) begin
        b = ampPWM;
        return;
      end
    end
    check("bit_timeout", n, 0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic b, st, ur;
    int   n, ones1, ones2, urs, ones, k;
    int   t5_exp[4];
    t5_exp = '{0, 1, 1, 1};
    sif.s_valid = 1'b0;
    sif.s_data  = '0;

    repeat (3) @(negedge clk);
    check("reset_outputs", {mclk, ampPWM, ampSD, sif.s_ready, sample_tick, underrun}, 6'b0);
    reset = 1'b1;
    cycle();
    check("off_after_release", {ampSD, mclk, sif.s_ready}, 3'b0);

    // Enable with no samples: boundary with underrun, sample 0 gives 0,1,0,1
    enable = 1'b1;
    next_bit(b, st, ur, n);
    check("t1_first_tick_latency", n, 3);
    check("t1_first_sample_tick", st, 1);
    check("t1_first_underrun", ur, 1);
    check("t1_first_bit", b, 0);
    check("t1_ampsd_on", ampSD, 1);
    for (int i = 0; i < 3; i++) begin
      next_bit(b, st, ur, n);
      check($sformatf("t1_bit%0d", i + 1), b, (i % 2 == 0) ? 1 : 0);
      check($sformatf("t1_period%0d", i + 1), n, 4);
    end

    // Fresh start, then 0x8000 and 0x7FFF frames
    enable = 1'b0;
    cycle();
    enable = 1'b1;
    feed_q.push_back(16'h8000);
    feed_q.push_back(16'h7FFF);
    ones1 = 0;
    ones2 = 0;
    urs   = 0;
    for (int i = 1; i <= 16; i++) begin
      next_bit(b, st, ur, n);
      if (ur) urs++;
      if (i == 1) check("t2_f1_sample_tick", st, 1);
      if (i == 9) begin
        check("t2_f2_sample_tick", st, 1);
        check("t2_f2_first_bit", b, 0);
      end
      if (i <= 8) ones1 += int'(b);
      else if (i >= 10) ones2 += int'(b);
      if (i == 15) begin
        endless_val = 16'h4000;
        endless     = 1'b1;
      end
    end
    check("t2_f1_ones", ones1, 0);
    check("t2_f2_ones_after_first", ones2, 7);
    check("t2_underruns", urs, 0);

    // Continuous valid of 0x4000 across 256 bits
    win  = 1'b1;
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      next_bit(b, st, ur, n);
      ones += int'(b);
    end
    win = 1'b0;
    check("t4_ones_256", ones, 192);
    check("t3_accepts", win_acc, 32);
    check("t3_sample_ticks", win_st, 32);
    check("t3_underruns", win_ur, 0);
    check("t3_ready_only_on_boundary", win_rdy_mis, 0);

    // Drop enable while mclk and ampPWM are both high
    endless = 1'b0;
    k = 0;
    while (!(mclk && ampPWM) && k < 64) begin
      cycle();
      k++;
    end
    check("t5_found_high_phase", {mclk, ampPWM}, 2'b11);
    enable = 1'b0;
    cycle();
    check("t5_off_outputs", {mclk, ampPWM, ampSD, sif.s_ready}, 4'b0);
    cycle();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_bit(b, st, ur, n);
      if (i == 0) begin
        check("t5_reenable_sample_tick", st, 1);
        check("t5_reenable_underrun", ur, 1);
      end
      check($sformatf("t5_bit%0d", i), b, t5_exp[i]);
    end

    // Asynchronous reset between clock edges
    k = 0;
    while (!mclk && k < 64) begin
      cycle();
      k++;
    end
    #2 reset = 1'b0;
    #1 check("t6_async_clear", {mclk, ampPWM, ampSD, sif.s_ready, sample_tick, underrun}, 6'b0);
    enable = 1'b0;
    @(negedge clk);
    reset     = 1'b1;
    prev_mclk = 1'b0;
    repeat (3) cycle();
    check("t6_off_after_release", {mclk, ampSD, sif.s_ready}, 3'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pdm_tx.md
Name: pdm_tx

Overview:
- Transmit-side counterpart of the microphone PDM capture path.
- Accepts signed PCM samples over a valid/ready handshake.
- Generates the PDM bit clock and converts each sample to a 1-bit pulse-density stream with a first-order sigma-delta modulator.
- Drives the audio amplifier pins (ampPWM/ampSD) directly, replacing the raw mic-bit passthrough when playing synthesized game audio.

Parameters:
CLK_DIV, 50, clk cycles per mclk half-period (mclk period = 2*CLK_DIV clk cycles; 100 MHz -> 1 MHz)
DATA_W, 16, PCM sample width, signed two's complement
OSR, 64, PDM bits per PCM sample (oversampling ratio)

Ports:
clk  in  1  system clock, single clock domain
reset  in  1  asynchronous, active-low reset
enable  in  1  run request; low = amplifier shut down, block idle
s_data  in  DATA_W  PCM sample, signed
s_valid  in  1  sample valid
s_ready  out  1  block can accept s_data this cycle
mclk  out  1  PDM bit clock
ampPWM  out  1  PDM data bit
ampSD  out  1  amplifier enable (1 = amplifier on)
sample_tick  out  1  one-clk pulse at each sample-frame boundary
underrun  out  1  one-clk pulse: frame boundary with no pending sample

Behaviour:
- Reset (reset=0, async): all outputs 0; divider, osr_cnt, accumulator, current sample, pending slot cleared; state OFF.
- States:
  - OFF: mclk=0, ampPWM=0, ampSD=0, s_ready=0. enable=1 -> RUN next cycle; osr_cnt preset to OSR-1; div_cnt=0.
  - RUN: ampSD=1. enable=0 -> OFF next cycle; pending slot flushed, accumulator cleared, mclk forced 0 (a truncated mclk high phase is allowed).
- Divider:
  - div_cnt counts 0..CLK_DIV-1; at CLK_DIV-1 it wraps and mclk toggles.
  - bit_tick = the clk cycle where mclk goes 0->1.
- Modulator (on bit_tick only):
  - u = cur_sample with MSB inverted (offset binary).
  - acc is DATA_W+1 bits; sum = {1'b0, acc[DATA_W-1:0]} + u.
  - ampPWM <= sum[DATA_W]; acc <= sum.
  - ampPWM is registered, changes only with mclk rising, and is stable for a full mclk period; the consumer samples on mclk falling.
  - Long-run density of 1s = u / 2^DATA_W.
- Frame counter:
  - osr_cnt increments on bit_tick and wraps at OSR-1.
  - A bit_tick with osr_cnt==OSR-1 is a frame boundary:
    - sample_tick=1 for that cycle.
    - If pending valid: cur_sample <= pending, pending cleared.
    - Else: cur_sample held, underrun=1 for that cycle.
  - The loaded sample governs the modulator from the same bit_tick onward.
  - The first tick after entering RUN is a frame boundary.
- Handshake:
  - One pending slot. s_ready = RUN & (!pend_full | frame_load_this_cycle).
  - Transfer when s_valid & s_ready.
  - Simultaneous load and accept in one cycle: the old pending goes to cur_sample and the new data goes to pending (no loss, no bubble).
  - Data offered while s_ready=0 is ignored; the source holds it.
- Latency: an accepted sample reaches ampPWM at the next frame boundary (at most OSR mclk periods plus 1 clk).
- Arithmetic: no saturation needed; the accumulator wraps by construction. Extremes: 0x7FFF gives all 1s except one 0 per 2^DATA_W bits; 0x8000 gives all 0s.
- enable toggled while reset=0: OFF/RUN transitions apply as above. Reset asserted mid-frame: immediate async clear.

Decomposition:
- Package pdm_pkg:
  - State enum {OFF, RUN}.
  - Default constants: CLK_DIV, DATA_W, OSR.
  - Function to_offset(), which inverts the MSB.
- One sub-module pdm_clk_gen (div_cnt, mclk, bit_tick; inputs run/clear). The modulator, frame counter and handshake stay in pdm_tx.

Test Plan:
- Reset, then enable=1 with CLK_DIV=2, no samples -> mclk period 4 clk; first bit_tick raises sample_tick and underrun; ampPWM follows sample 0x0000: 0,1,0,1...; ampSD=1.
- Push 0x8000 then 0x7FFF (OSR=8) -> frame 1 ampPWM all 0; frame 2 ampPWM 0 then 1 on the following 7 ticks (acc carry pattern); no underrun while samples keep pace.
- Hold s_valid=1 continuously -> s_ready drops after pending fills and re-asserts exactly on frame-boundary cycles; each accept pairs with one sample_tick; no sample skipped or duplicated.
- Sample 0x4000 (u=0xC000) for 256 ticks -> count of 1s = 192 ±1.
- Drop enable mid-frame -> next cycle mclk=0, ampPWM=0, ampSD=0, s_ready=0; re-enable -> first tick is a frame boundary, acc restarts from 0, pending empty (underrun pulse).
- Assert reset asynchronously between clk edges -> all outputs 0 before the next clk edge; release -> state OFF.
